// File: rtl/bcd_to_bin.sv
// Two-digit packed BCD (00..99) to 7-bit binary converter.
// One registered stage: a sample taken on one clock edge is presented on the
// outputs after that edge, with outValid marking the cycle it is new.
// A tens or ones nibble above 9 returns binOut=0 with err=1.
module bcd_to_bin (
  input  logic       clk,
  input  logic       rst,
  input  logic       inValid,
  input  logic [7:0] bcdIn,
  output logic       outValid,
  output logic [6:0] binOut,
  output logic       err
);

  logic [3:0] tensDigit;
  logic [3:0] onesDigit;
  logic       tensBad;
  logic       onesBad;
  logic       digitErr;
  logic [6:0] tensWide;
  logic [6:0] tensTimesTen;
  logic [6:0] sumBin;
  logic [6:0] binNext;

  // Split the digits, range-check them and form tens*10 + ones with shifts and adds.
  always_comb begin
    tensDigit    = bcdIn[7:4];
    onesDigit    = bcdIn[3:0];
    tensBad      = (tensDigit > 4'd9);
    onesBad      = (onesDigit > 4'd9);
    digitErr     = tensBad | onesBad;
    tensWide     = {3'b000, tensDigit};
    // tens*10 = tens*8 + tens*2; at most 90, so 7 bits are enough for legal digits.
    tensTimesTen = (tensWide << 3) + (tensWide << 1);
    sumBin       = tensTimesTen + {3'b000, onesDigit};
    binNext      = digitErr ? 7'd0 : sumBin;
  end

  // Output register: reset clears everything, otherwise capture valid samples and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      binOut   <= 7'd0;
      err      <= 1'b0;
    end else begin
      outValid <= inValid;
      if (inValid) begin
        binOut <= binNext;
        err    <= digitErr;
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: directed vector table, exhaustive sweep and random stream.
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic [7:0] bcdIn;
  logic       outValid;
  logic [6:0] binOut;
  logic       err;

  int total = 0;
  int bad   = 0;

  // Reference state, computed from decimal digit arithmetic.
  logic mValid;
  int   mBin;
  logic mErr;

  typedef struct {
    string      name;
    logic       r;
    logic       v;
    logic [7:0] b;
    logic       eValid;
    logic [6:0] eBin;
    logic       eErr;
  } vec_t;

  vec_t vecs[19];

  always #5 clk = ~clk;

  bcd_to_bin dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .bcdIn    (bcdIn),
    .outValid (outValid),
    .binOut   (binOut),
    .err      (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of input, then advance the reference model.
  task automatic cycle(input logic r, input logic v, input logic [7:0] b);
    int tens;
    int ones;
    rst     = r;
    inValid = v;
    bcdIn   = b;
    @(posedge clk);
    #1;
    tens = int'(b) / 16;
    ones = int'(b) % 16;
    if (r) begin
      mValid = 1'b0;
      mBin   = 0;
      mErr   = 1'b0;
    end else begin
      mValid = v;
      if (v) begin
        if (tens < 10 && ones < 10) begin
          mBin = tens * 10 + ones;
          mErr = 1'b0;
        end else begin
          mBin = 0;
          mErr = 1'b1;
        end
      end
    end
  endtask

  task automatic checkModel(input string name);
    check({name, ".valid"}, {31'd0, outValid}, {31'd0, mValid});
    check({name, ".bin"}, {25'd0, binOut}, mBin);
    check({name, ".err"}, {31'd0, err}, {31'd0, mErr});
  endtask

  initial begin
    rst     = 1'b1;
    inValid = 1'b1;
    bcdIn   = 8'h55;
    mValid  = 1'b0;
    mBin    = 0;
    mErr    = 1'b0;

    vecs[0]  = '{"rst0",     1'b1, 1'b1, 8'h55, 1'b0, 7'd0,  1'b0};
    vecs[1]  = '{"rst1",     1'b1, 1'b1, 8'h55, 1'b0, 7'd0,  1'b0};
    vecs[2]  = '{"h87",      1'b0, 1'b1, 8'h87, 1'b1, 7'd87, 1'b0};
    vecs[3]  = '{"h00",      1'b0, 1'b1, 8'h00, 1'b1, 7'd0,  1'b0};
    vecs[4]  = '{"h09",      1'b0, 1'b1, 8'h09, 1'b1, 7'd9,  1'b0};
    vecs[5]  = '{"h90",      1'b0, 1'b1, 8'h90, 1'b1, 7'd90, 1'b0};
    vecs[6]  = '{"h99",      1'b0, 1'b1, 8'h99, 1'b1, 7'd99, 1'b0};
    vecs[7]  = '{"h1A",      1'b0, 1'b1, 8'h1A, 1'b1, 7'd0,  1'b1};
    vecs[8]  = '{"hC3",      1'b0, 1'b1, 8'hC3, 1'b1, 7'd0,  1'b1};
    vecs[9]  = '{"h42",      1'b0, 1'b1, 8'h42, 1'b1, 7'd42, 1'b0};
    vecs[10] = '{"h87b",     1'b0, 1'b1, 8'h87, 1'b1, 7'd87, 1'b0};
    vecs[11] = '{"idle12",   1'b0, 1'b0, 8'h12, 1'b0, 7'd87, 1'b0};
    vecs[12] = '{"h0A",      1'b0, 1'b1, 8'h0A, 1'b1, 7'd0,  1'b1};
    vecs[13] = '{"idleErr",  1'b0, 1'b0, 8'h33, 1'b0, 7'd0,  1'b1};
    vecs[14] = '{"hA0",      1'b0, 1'b1, 8'hA0, 1'b1, 7'd0,  1'b1};
    vecs[15] = '{"hFF",      1'b0, 1'b1, 8'hFF, 1'b1, 7'd0,  1'b1};
    vecs[16] = '{"h55",      1'b0, 1'b1, 8'h55, 1'b1, 7'd55, 1'b0};
    vecs[17] = '{"rstMid",   1'b1, 1'b1, 8'h33, 1'b0, 7'd0,  1'b0};
    vecs[18] = '{"afterRst", 1'b0, 1'b1, 8'h21, 1'b1, 7'd21, 1'b0};

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].b);
      check({vecs[i].name, ".valid"}, {31'd0, outValid}, {31'd0, vecs[i].eValid});
      check({vecs[i].name, ".bin"}, {25'd0, binOut}, {25'd0, vecs[i].eBin});
      check({vecs[i].name, ".err"}, {31'd0, err}, {31'd0, vecs[i].eErr});
    end

    // Exhaustive sweep of every input byte, back-to-back.
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 1'b1, 8'(i));
      checkModel($sformatf("sweep%02h", i));
    end

    // Valid sample followed by reset on the next edge: result is cleared.
    cycle(1'b0, 1'b1, 8'h64);
    checkModel("preRst");
    cycle(1'b1, 1'b0, 8'h00);
    checkModel("rstAfterInput");
    cycle(1'b0, 1'b0, 8'h77);
    checkModel("idleAfterRst");
    cycle(1'b0, 1'b1, 8'h38);
    checkModel("firstAfterRst");

    // Random stream with idle cycles and occasional resets.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
      checkModel($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
